uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter: next generation of the team's fixed 8N1 serial TX.
- Adds a configurable bit period, data width, parity mode and stop-bit count.
- Adds a write-side FIFO so software/keyboard logic can queue bytes without polling busy.
- Sits between the keyboard/command logic and the board TX pin, in the single system clock domain.

Parameters:
CLK_DIV, 434, clock cycles per serial bit (>=2); 434 = 115200 baud at 50 MHz
DATA_BITS, 8, payload bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >=2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
wr_en  input  1  push wr_data into FIFO when high and full==0
wr_data  input  DATA_BITS  character to send
full  output  1  FIFO holds FIFO_DEPTH entries
empty  output  1  FIFO holds 0 entries
level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  output  1  one-cycle pulse: wr_en while full, data dropped
busy  output  1  high when FSM not IDLE or FIFO not empty
tx  output  1  serial line, idle high

Behaviour:
- Reset (async on rst high): tx=1, full=0, empty=1, level=0, overflow=0, busy=0, FSM=IDLE, pointers and bit/baud counters 0. Asserting rst mid-frame aborts the frame immediately (tx=1 same instant) and discards FIFO contents.
- FIFO: registered count. full/empty/level reflect state after the last edge.
  - Write accepted iff wr_en && !full, decided on the pre-edge full.
  - Write while full is rejected even if a pop occurs in the same cycle; overflow=1 for that one cycle.
  - Simultaneous accepted write and pop: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If !empty at an edge: pop head into shift register, tx=0, go START, baud counter=0.
  - Every non-IDLE state lasts exactly CLK_DIV cycles per bit. The baud counter counts 0..CLK_DIV-1; the bit advances on the edge where counter==CLK_DIV-1.
  - START -> DATA. DATA sends DATA_BITS bits, LSB first.
  - DATA -> PARITY if PARITY!=0, else STOP.
  - PARITY bit: even mode = XOR of data bits; odd mode = inverted XOR.
  - STOP: tx=1 for STOP_BITS bit periods.
  - At the end of the final stop period: if !empty, pop and drive tx=0 on that same edge (no idle gap between frames); else go IDLE.
- Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles.
- Latency, write into an empty FIFO with FSM in IDLE:
  - wr_en sampled at edge k -> empty=0 after k.
  - Pop at edge k+1 -> tx falls at edge k+1, empty=1 again after k+1.
- wr_data is captured at the write edge. Later changes of wr_data do not affect queued words.
- busy falls on the edge the FSM enters IDLE with the FIFO empty.
- tx is a register output, glitch-free. No combinational path from inputs to tx.
- Illegal parameter values are not supported; the bench covers only the legal ranges.

Test Plan:
1. Defaults scaled to CLK_DIV=4, 8N1: write 0x55 once -> tx low 4 cycles starting edge k+1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high; frame = 40 cycles, busy drops at its end.
2. PARITY=2, STOP_BITS=2, DATA_BITS=7, CLK_DIV=4: send 0x41 -> start, bits 1,0,0,0,0,0,1, parity 0, two stop periods = 44 cycles. With PARITY=1 the parity bit=1.
3. FIFO_DEPTH=4: write 0x01..0x06 on six consecutive cycles from idle:
   - the first word pops at the second edge, so 0x02..0x05 fill the FIFO;
   - 0x06 write sees full=1 -> overflow pulses one cycle, 0x06 dropped;
   - tx emits exactly 0x01..0x05 back-to-back with no idle cycles between frames.
4. Simultaneous push and pop: FIFO level=2 with a frame ending; write on the pop edge -> level stays 2, no overflow.
5. Reset mid-frame: assert rst during DATA bit 3 with 3 words queued -> tx=1 immediately, empty=1, level=0, busy=0. After release, a new write transmits normally.
6. Idle behaviour: no writes for 1000 cycles after reset -> tx held 1, busy=0, overflow never asserted.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - parametrised UART transmitter with a write-side FIFO
module uart_tx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           bitcnt, bitcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 tx_n;
  logic                 bit_end;

  assign full    = (count == LW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign busy    = (state != ST_IDLE) || !empty;
  assign push    = wr_en && !full;
  assign head    = mem[rd_ptr];
  assign bit_end = (cnt == CW'(CLK_DIV - 1));

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
      par    <= 1'b0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
      sh     <= sh_n;
      par    <= par_n;
      tx     <= tx_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    sh_n     = sh;
    par_n    = par;
    tx_n     = tx;
    pop      = 1'b0;

    if (state == ST_IDLE) begin
      tx_n = 1'b1;
      if (!empty) begin
        pop     = 1'b1;
        sh_n    = head;
        par_n   = (PARITY == 1) ? ~(^head) : ^head;
        tx_n    = 1'b0;
        cnt_n   = '0;
        state_n = ST_START;
      end
    end else if (!bit_end) begin
      cnt_n = cnt + CW'(1);
    end else begin
      cnt_n = '0;
      case (state)
        ST_START: begin
          tx_n     = sh[0];
          sh_n     = sh >> 1;
          bitcnt_n = '0;
          state_n  = ST_DATA;
        end
        ST_DATA: begin
          if (bitcnt == 4'(DATA_BITS - 1)) begin
            bitcnt_n = '0;
            if (PARITY != 0) begin
              tx_n    = par;
              state_n = ST_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_STOP;
            end
          end else begin
            tx_n     = sh[0];
            sh_n     = sh >> 1;
            bitcnt_n = bitcnt + 4'd1;
          end
        end
        ST_PARITY: begin
          tx_n     = 1'b1;
          bitcnt_n = '0;
          state_n  = ST_STOP;
        end
        ST_STOP: begin
          if (bitcnt != 4'(STOP_BITS - 1)) begin
            bitcnt_n = bitcnt + 4'd1;
          end else if (!empty) begin
            // Back-to-back frames: the next start bit begins on this edge.
            pop      = 1'b1;
            sh_n     = head;
            par_n    = (PARITY == 1) ? ~(^head) : ^head;
            tx_n     = 1'b0;
            bitcnt_n = '0;
            state_n  = ST_START;
          end else begin
            tx_n     = 1'b1;
            bitcnt_n = '0;
            state_n  = ST_IDLE;
          end
        end
        default: begin
          tx_n    = 1'b1;
          state_n = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed table-driven bench for uart_tx_fifo
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic [2:0] tx_b, busy_b, full_b, empty_b, ovf_b;
  logic [2:0] level_v [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // u0: 8N1, u1: 7E2, u2: 7O2; all CLK_DIV=4, FIFO_DEPTH=4
  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_b[0]), .empty(empty_b[0]), .level(level_v[0]),
    .overflow(ovf_b[0]), .busy(busy_b[0]), .tx(tx_b[0]));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[6:0]),
    .full(full_b[1]), .empty(empty_b[1]), .level(level_v[1]),
    .overflow(ovf_b[1]), .busy(busy_b[1]), .tx(tx_b[1]));

  uart_tx_fifo #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data[6:0]),
    .full(full_b[2]), .empty(empty_b[2]), .level(level_v[2]),
    .overflow(ovf_b[2]), .busy(busy_b[2]), .tx(tx_b[2]));

  typedef struct {
    int         sel;
    logic [7:0] data;
    string      seq;
  } frame_t;

  frame_t rows [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Writes one word and checks tx cycle by cycle against seq (char i = serial bit i).
  task automatic send_frame(input int sel, input logic [7:0] d, input string seq, input string nm);
    int n;
    n = seq.len();
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    chk({nm, "_empty_after_write"}, int'(empty_b[sel]), 0);
    chk({nm, "_level_after_write"}, int'(level_v[sel]), 1);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        tick();
        chk($sformatf("%s_bit%0d_c%0d", nm, i, j), int'(tx_b[sel]), (seq[i] == "1") ? 1 : 0);
        if (i == 0 && j == 0) chk({nm, "_empty_after_pop"}, int'(empty_b[sel]), 1);
        if (i == n - 1 && j == 3) chk({nm, "_busy_last"}, int'(busy_b[sel]), 1);
      end
    end
    tick();
    chk({nm, "_busy_end"}, int'(busy_b[sel]), 0);
    chk({nm, "_tx_end"}, int'(tx_b[sel]), 1);
  endtask

  function automatic int exp_bit(input int c);
    int f, b, d;
    f = c / 40;
    b = (c % 40) / 4;
    d = f + 1;
    if (b == 0) return 0;
    if (b == 9) return 1;
    return (d >> (b - 1)) & 1;
  endfunction

  initial begin
    int mism, c, bad_tx, bad_busy, bad_ovf;

    rows[0] = '{0, 8'h55, "0101010101"};
    rows[1] = '{0, 8'hA3, "0110001011"};
    rows[2] = '{1, 8'h41, "01000001011"};
    rows[3] = '{2, 8'h41, "01000001111"};
    rows[4] = '{1, 8'h07, "01110000111"};
    rows[5] = '{0, 8'h00, "0000000001"};
    rows[6] = '{0, 8'hFF, "0111111111"};

    do_reset();
    chk("rst_tx", int'(tx_b[0]), 1);
    chk("rst_full", int'(full_b[0]), 0);
    chk("rst_empty", int'(empty_b[0]), 1);
    chk("rst_level", int'(level_v[0]), 0);
    chk("rst_overflow", int'(ovf_b[0]), 0);
    chk("rst_busy", int'(busy_b[0]), 0);

    for (int r = 0; r < 7; r++) begin
      do_reset();
      send_frame(rows[r].sel, rows[r].data, rows[r].seq, $sformatf("row%0d", r));
    end

    // Six consecutive writes into depth 4: 0x06 dropped, 0x01..0x05 back-to-back.
    do_reset();
    mism = 0;
    c = 0;
    for (int n = 0; n < 6; n++) begin
      wr_en = 1'b1;
      wr_data = 8'(n + 1);
      tick();
      if (n >= 1) begin
        if (int'(tx_b[0]) != exp_bit(c)) mism++;
        c++;
      end
      if (n == 4) begin
        chk("burst_full", int'(full_b[0]), 1);
        chk("burst_level4", int'(level_v[0]), 4);
        chk("burst_no_ovf_yet", int'(ovf_b[0]), 0);
      end
      if (n == 5) begin
        chk("burst_overflow", int'(ovf_b[0]), 1);
        chk("burst_level_kept", int'(level_v[0]), 4);
      end
    end
    wr_en = 1'b0;
    while (c < 200) begin
      tick();
      if (c == 5) chk("burst_ovf_one_cycle", int'(ovf_b[0]), 0);
      if (int'(tx_b[0]) != exp_bit(c)) mism++;
      if (busy_b[0] != 1'b1) mism++;
      c++;
    end
    chk("burst_stream_mismatches", mism, 0);
    chk("burst_level_drained", int'(level_v[0]), 0);
    tick();
    chk("burst_busy_end", int'(busy_b[0]), 0);
    chk("burst_tx_end", int'(tx_b[0]), 1);

    // Push on the same edge a frame ends and pops the next word.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      wr_en = 1'b1;
      wr_data = 8'h11 * (n + 1);
      tick();
    end
    wr_en = 1'b0;
    chk("pp_level_before", int'(level_v[0]), 2);
    for (int n = 0; n < 38; n++) tick();
    chk("pp_level_stop", int'(level_v[0]), 2);
    chk("pp_tx_stop", int'(tx_b[0]), 1);
    wr_en = 1'b1;
    wr_data = 8'h44;
    tick();
    wr_en = 1'b0;
    chk("pp_level_same", int'(level_v[0]), 2);
    chk("pp_no_overflow", int'(ovf_b[0]), 0);
    chk("pp_next_start", int'(tx_b[0]), 0);

    // Asynchronous reset during data bit 3 with words queued.
    do_reset();
    for (int n = 0; n < 4; n++) begin
      wr_en = 1'b1;
      wr_data = 8'(n);
      tick();
    end
    wr_en = 1'b0;
    chk("mr_level_queued", int'(level_v[0]), 3);
    for (int n = 0; n < 15; n++) tick();
    chk("mr_tx_data_low", int'(tx_b[0]), 0);
    chk("mr_busy_before", int'(busy_b[0]), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_tx", int'(tx_b[0]), 1);
    chk("mr_empty", int'(empty_b[0]), 1);
    chk("mr_level", int'(level_v[0]), 0);
    chk("mr_busy", int'(busy_b[0]), 0);
    chk("mr_full", int'(full_b[0]), 0);
    tick();
    rst = 1'b0;
    tick();
    send_frame(0, 8'h55, "0101010101", "mr_after");

    // Long idle after reset.
    do_reset();
    bad_tx = 0;
    bad_busy = 0;
    bad_ovf = 0;
    for (int n = 0; n < 1000; n++) begin
      tick();
      if (tx_b[0] != 1'b1) bad_tx++;
      if (busy_b[0] != 1'b0) bad_busy++;
      if (ovf_b[0] != 1'b0) bad_ovf++;
    end
    chk("idle_tx_high", bad_tx, 0);
    chk("idle_busy_low", bad_busy, 0);
    chk("idle_no_overflow", bad_ovf, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
